// File: rtl/rsa_modexp.sv
// rsa_modexp: sequential modular exponentiation engine, OUT_MSG = IN_MSG^IN_EXP mod IN_N.
// It processes one exponent bit per cycle, using right-to-left square-and-multiply.
// The same engine encrypts (exponent E) and decrypts (exponent D).
//
// Ports (KW = 2*WIDTH):
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request strobe, sampled only while in_ready=1
//   in_ready   1 while idle and able to accept a request
//   IN_MSG     [KW] message operand
//   IN_EXP     [KW] exponent
//   IN_N       [KW] modulus
//   out_valid  one-cycle result strobe
//   OUT_MSG    [KW] result, 0 whenever out_valid=0
//
// Timing: the request is accepted at edge k. Calculation runs for KW cycles. The result is
// presented after edge k+KW+1, in the same cycle that in_ready returns high.
module rsa_modexp #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   IN_MSG,
  input  logic [2*WIDTH-1:0]   IN_EXP,
  input  logic [2*WIDTH-1:0]   IN_N,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   OUT_MSG
);

  localparam int unsigned KW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(KW + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [KW-1:0]   n_q;
  logic [KW-1:0]   exp_q;
  logic [KW-1:0]   base_q;
  logic [KW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;

  // The divider is never evaluated with a zero modulus. A modulus of 0 or 1 yields 0.
  function automatic logic [KW-1:0] mod_n(input logic [2*KW-1:0] x, input logic [KW-1:0] m);
    logic [2*KW-1:0] r;
    if (m <= KW'(1)) begin
      r = '0;
    end else begin
      r = x % {{KW{1'b0}}, m};
    end
    return r[KW-1:0];
  endfunction

  logic [2*KW-1:0] prod_acc;
  logic [2*KW-1:0] prod_sq;
  logic [KW-1:0]   acc_mul;
  logic [KW-1:0]   base_sq;
  logic [KW-1:0]   base_load;

  always_comb begin
    prod_acc  = {{KW{1'b0}}, acc_q} * {{KW{1'b0}}, base_q};
    prod_sq   = {{KW{1'b0}}, base_q} * {{KW{1'b0}}, base_q};
    acc_mul   = mod_n(prod_acc, n_q);
    base_sq   = mod_n(prod_sq, n_q);
    base_load = mod_n({{KW{1'b0}}, IN_MSG}, IN_N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_q       <= '0;
      exp_q     <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      OUT_MSG   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          out_valid <= 1'b0;
          OUT_MSG   <= '0;
          if (in_valid) begin
            n_q      <= IN_N;
            exp_q    <= IN_EXP;
            base_q   <= base_load;
            // 1 mod n: this is 0 when the modulus is 0 or 1.
            acc_q    <= (IN_N > KW'(1)) ? KW'(1) : '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          if (exp_q[0]) begin
            acc_q <= acc_mul;
          end
          base_q <= base_sq;
          exp_q  <= exp_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          // Every exponent bit is processed, so latency does not depend on the exponent value.
          if (cnt_q == CW'(KW - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          out_valid <= 1'b1;
          OUT_MSG   <= acc_q;
          in_ready  <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
module tb_rsa_modexp;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned KW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] in_msg = '0;
  logic [KW-1:0] in_exp = '0;
  logic [KW-1:0] in_n = '0;
  logic          out_valid;
  logic [KW-1:0] out_msg;

  int total = 0;
  int bad   = 0;

  rsa_modexp #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IN_MSG   (in_msg),
    .IN_EXP   (in_exp),
    .IN_N     (in_n),
    .out_valid(out_valid),
    .OUT_MSG  (out_msg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference result computed by repeated multiplication.
  function automatic int modexp(input int m, input int e, input int n);
    longint r;
    longint b;
    if (n <= 1) return 0;
    r = 1;
    b = longint'(m) % longint'(n);
    for (int i = 0; i < e; i++) r = (r * b) % longint'(n);
    return int'(r);
  endfunction

  // Transaction-level model: it accepts when idle, and the answer appears KW+1 edges later.
  logic          m_idle;
  logic          m_valid;
  logic [KW-1:0] m_msg;
  logic [KW-1:0] m_res;
  int unsigned   m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_msg   <= '0;
      m_res   <= '0;
      m_age   <= 0;
    end else if (m_idle) begin
      m_valid <= 1'b0;
      m_msg   <= '0;
      if (in_valid) begin
        m_res  <= KW'(modexp(int'(in_msg), int'(in_exp), int'(in_n)));
        m_age  <= 0;
        m_idle <= 1'b0;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == KW) begin
        m_valid <= 1'b1;
        m_msg   <= m_res;
        m_idle  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_in_ready", in_ready, m_idle);
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_out_msg", out_msg, m_msg);
    end
  end

  task automatic run_req(input int m, input int e, input int n, input int want,
                         input string name);
    int waitc;
    int lat;
    waitc = 0;
    lat   = 0;
    @(negedge clk);
    while (!in_ready && waitc < 30) begin
      @(negedge clk);
      waitc++;
    end
    check({name, "_ready"}, in_ready, 1);
    in_msg   = KW'(m);
    in_exp   = KW'(e);
    in_n     = KW'(n);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Operands only matter on the accepting edge.
    in_msg   = KW'($urandom);
    in_exp   = KW'($urandom);
    in_n     = KW'($urandom);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 7);
    check({name, "_result"}, out_msg, want);
  endtask

  initial begin
    int pulses;
    int busy;
    int pr[4];
    int p;
    int q;
    int n;
    int lam;
    int e;
    int d;
    int m;
    int c;
    int g;
    int a;
    int b;
    pr[0] = 2; pr[1] = 3; pr[2] = 5; pr[3] = 7;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_msg", out_msg, 0);
    rst_n = 1'b1;

    // Directed vectors.
    run_req(7, 3, 15, 13, "enc15");
    run_req(13, 3, 15, 7, "dec15");
    run_req(2, 5, 35, 32, "enc35");
    run_req(32, 29, 35, 2, "dec35");
    run_req(9, 0, 15, 1, "exp0");
    run_req(5, 3, 1, 0, "n1");
    run_req(11, 5, 0, 0, "n0");
    run_req(48, 63, 49, 48, "n49");
    run_req(63, 1, 15, 3, "msg_ge_n");
    run_req(0, 5, 35, 0, "msg0");

    // Busy: in_valid is held high with changing operands, so three operations fit in 24 cycles.
    @(negedge clk);
    in_valid = 1'b1;
    pulses   = 0;
    busy     = 0;
    for (int i = 0; i < 24; i++) begin
      in_msg = KW'($urandom);
      in_exp = KW'($urandom);
      in_n   = KW'($urandom);
      @(negedge clk);
      if (out_valid) pulses++;
      if (!in_ready) busy++;
    end
    in_valid = 1'b0;
    check("busy_pulses", pulses, 3);
    check("busy_ready_low", busy, 21);
    repeat (10) @(negedge clk);

    // Reset is asserted during CALC cycle 3.
    in_msg   = 6'd7;
    in_exp   = 6'd3;
    in_n     = 6'd15;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_msg", out_msg, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    run_req(7, 3, 15, 13, "after_rst");

    // Random key pairs with distinct primes P and Q, encrypted and then decrypted.
    for (int t = 0; t < 250; t++) begin
      p = pr[$urandom_range(0, 3)];
      do q = pr[$urandom_range(0, 3)]; while (q == p);
      n = p * q;
      a = p - 1;
      b = q - 1;
      g = a;
      while (b != 0) begin
        c = g % b;
        g = b;
        b = c;
      end
      lam = ((p - 1) * (q - 1)) / g;
      do begin
        e = int'($urandom_range(1, 63));
        a = e;
        b = lam;
        while (b != 0) begin
          c = a % b;
          a = b;
          b = c;
        end
      end while (a != 1);
      d = 0;
      for (int k = 1; k <= lam; k++) if (d == 0 && (e * k) % lam == 1) d = k;
      m = int'($urandom_range(0, n - 1));
      c = modexp(m, e, n);
      run_req(m, e, n, c, "rnd_enc");
      run_req(c, d, n, m, "rnd_dec");
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
